// File: rtl/grid_cond_pkg.sv
// Shared constants for the grid sample conditioner: FSM encoding and derived widths.
// Default-build constants match DATA_WIDTH=12, AVG_LOG2=2.
package grid_cond_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 12;
    localparam int unsigned DEF_AVG_LOG2   = 2;

    localparam int unsigned ACC_WIDTH  = DEF_DATA_WIDTH + 1 + DEF_AVG_LOG2;
    localparam int unsigned FULL_SCALE = (1 << DEF_DATA_WIDTH) - 1;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned al);
        return dw + 1 + al;
    endfunction

    // A zero-width counter is illegal, so pass-through mode keeps one constant-zero bit.
    function automatic int unsigned cnt_width(input int unsigned al);
        return (al > 0) ? al : 1;
    endfunction

endpackage

// File: rtl/grid_sample_conditioner_sample_accumulator.sv
// Offset removal, signed block accumulator and sample counter.
// Emits a combinational done pulse and the floored block average on the last accepted sample.
module sample_accumulator
    import grid_cond_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int          OFFSET     = 2048
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               sample,
    input  logic                                accept,
    output logic                                done,
    output logic signed [DATA_WIDTH+AVG_LOG2:0] avg
);

    localparam int unsigned AW = acc_width(DATA_WIDTH, AVG_LOG2);
    localparam int unsigned CW = cnt_width(AVG_LOG2);

    localparam logic [CW-1:0]               CNT_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic signed [DATA_WIDTH:0]  OFF      = (DATA_WIDTH + 1)'(OFFSET);

    logic signed [DATA_WIDTH:0] d;
    logic signed [AW-1:0]       sum;
    logic signed [AW-1:0]       acc_q, acc_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       last;

    assign d    = $signed({1'b0, sample}) - OFF;
    assign sum  = acc_q + AW'(d);
    assign last = (cnt_q == CNT_LAST);
    assign done = accept && last;

    // Arithmetic shift floors toward -infinity.
    assign avg = sum >>> AVG_LOG2;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (accept) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/grid_sample_conditioner.sv
// Grid-voltage conditioner: offset removal and 2^AVG_LOG2 block averaging between AXIS ports.
// Optional sticky clip flag enabled by macro GRID_COND_CLIP_DETECT_EN.
module grid_sample_conditioner
    import grid_cond_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int          OFFSET     = 2048
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [OUT_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  clip_o
);

    logic [0:0]                  state_q, state_d;
    logic                        s_ready_q, s_ready_d;
    logic                        m_valid_q, m_valid_d;
    logic [OUT_WIDTH-1:0]        m_data_q, m_data_d;
    logic                        accept;
    logic                        done;
    logic signed [DATA_WIDTH+AVG_LOG2:0] avg;

    assign accept        = s_axis_tvalid && s_ready_q;
    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;

    sample_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .AVG_LOG2   (AVG_LOG2),
        .OFFSET     (OFFSET)
    ) u_acc (
        .clk    (Clk),
        .rst    (Reset),
        .sample (s_axis_tdata),
        .accept (accept),
        .done   (done),
        .avg    (avg)
    );

    // Ready is registered so it reads 0 throughout reset and rises on the first edge after.
    always_comb begin
        state_d   = state_q;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        unique case (state_q)
            ACCUM: begin
                s_ready_d = 1'b1;
                if (done) begin
                    m_data_d  = OUT_WIDTH'(avg);
                    m_valid_d = 1'b1;
                    s_ready_d = 1'b0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                s_ready_d = 1'b0;
                if (m_axis_tready) begin
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    state_d   = ACCUM;
                end
            end
            default: begin
                state_d   = ACCUM;
                s_ready_d = 1'b0;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ACCUM;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

`ifdef GRID_COND_CLIP_DETECT_EN
    logic clip_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clip_q <= 1'b0;
        end else if (accept && ((s_axis_tdata == '0) || (s_axis_tdata == '1))) begin
            clip_q <= 1'b1;
        end
    end

    assign clip_o = clip_q;
`else
    assign clip_o = 1'b0;
`endif

endmodule

// File: tb/tb_grid_sample_conditioner.sv
// Self-checking bench for grid_sample_conditioner at default parameters.
module tb_grid_sample_conditioner;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [11:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        clip_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0][11:0] s;
        logic [15:0]      exp;
    } vec_t;

    vec_t vecs[5];

    grid_sample_conditioner dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .clip_o        (clip_o)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one sample and return #1 after the edge that accepts it.
    task automatic put(input logic [11:0] v);
        int n;
        n = 0;
        @(negedge Clk);
        s_axis_tdata  = v;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (!s_axis_tready) begin
            checks++;
            failures++;
            $display("FAIL put_timeout: s_axis_tready stuck at 0 (required 1)");
        end
        @(posedge Clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    // Full block with m_axis_tready high: checks latency, value and one-cycle valid.
    task automatic run_block(input string name, input logic [3:0][11:0] s,
                             input logic [15:0] exp);
        for (int k = 0; k < 4; k++) begin
            put(s[k]);
            if (k < 3) check({name, "_early_valid"}, 32'(m_axis_tvalid), 32'd0);
        end
        check({name, "_valid"}, 32'(m_axis_tvalid), 32'd1);
        check({name, "_data"}, 32'(m_axis_tdata), 32'(exp));
        @(posedge Clk);
        #1;
        check({name, "_valid_drop"}, 32'(m_axis_tvalid), 32'd0);
        check({name, "_s_ready"}, 32'(s_axis_tready), 32'd1);
    endtask

    logic [15:0] exp_q[$];
    logic        exp_clip;

    initial begin
        vecs[0].s = {12'd2048, 12'd2048, 12'd2048, 12'd2048}; vecs[0].exp = 16'h0000;
        vecs[1].s = {12'd4095, 12'd4095, 12'd4095, 12'd4095}; vecs[1].exp = 16'h07FF;
        vecs[2].s = {12'd0,    12'd0,    12'd0,    12'd0};    vecs[2].exp = 16'hF800;
        vecs[3].s = {12'd1948, 12'd2148, 12'd2000, 12'd2100}; vecs[3].exp = 16'h0001;
        vecs[4].s = {12'd2048, 12'd2047, 12'd2047, 12'd2047}; vecs[4].exp = 16'hFFFF;
`ifdef GRID_COND_CLIP_DETECT_EN
        exp_clip = 1'b1;
`else
        exp_clip = 1'b0;
`endif

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("rst_s_ready", 32'(s_axis_tready), 32'd0);
        check("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_data", 32'(m_axis_tdata), 32'd0);
        check("rst_clip", 32'(clip_o), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("post_rst_s_ready", 32'(s_axis_tready), 32'd1);

        // Table of blocks
        for (int i = 0; i < 5; i++) begin
            run_block($sformatf("vec%0d", i), vecs[i].s, vecs[i].exp);
            if (i == 0) check("clip_clean", 32'(clip_o), 32'd0);
        end
        check("clip_after_rails", 32'(clip_o), 32'(exp_clip));

        // Backpressure: output must hold and input must stall
        m_axis_tready = 1'b0;
        put(12'd2048); put(12'd2048); put(12'd2048); put(12'd2052);
        check("hold_valid", 32'(m_axis_tvalid), 32'd1);
        check("hold_data", 32'(m_axis_tdata), 32'd1);
        @(negedge Clk);
        s_axis_tdata  = 12'd4095;
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge Clk);
            #1;
            check("hold_valid_stable", 32'(m_axis_tvalid), 32'd1);
            check("hold_data_stable", 32'(m_axis_tdata), 32'd1);
            check("hold_s_ready", 32'(s_axis_tready), 32'd0);
        end
        @(negedge Clk);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge Clk);
        #1;
        check("release_valid", 32'(m_axis_tvalid), 32'd0);
        check("release_s_ready", 32'(s_axis_tready), 32'd1);
        run_block("after_hold", {12'd2048, 12'd2048, 12'd2048, 12'd2048}, 16'h0000);

        // Asynchronous reset mid-block discards the partial sum
        put(12'd4095);
        put(12'd4095);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_s_ready", 32'(s_axis_tready), 32'd0);
        check("async_rst_clip", 32'(clip_o), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("async_rst_release", 32'(s_axis_tready), 32'd1);
        run_block("after_rst", {12'd2048, 12'd2048, 12'd2048, 12'd2048}, 16'h0000);

        // Random gaps and backpressure against a floor(sum/4) model
        begin
            int sent, rcvd, acc, cnt;
            bit pending;
            sent = 0; rcvd = 0; acc = 0; cnt = 0; pending = 0;
            for (int cyc = 0; cyc < 20000 && !(sent == 1000 && rcvd == 250); cyc++) begin
                @(negedge Clk);
                if (!pending) begin
                    if (sent < 1000 && $urandom_range(9) < 7) begin
                        s_axis_tdata  = 12'($urandom_range(4095));
                        s_axis_tvalid = 1'b1;
                        pending = 1;
                    end else begin
                        s_axis_tvalid = 1'b0;
                    end
                end
                m_axis_tready = ($urandom_range(9) < 8);
                if (s_axis_tvalid && s_axis_tready) begin
                    acc += int'({1'b0, s_axis_tdata}) - 2048;
                    cnt++;
                    if (cnt == 4) begin
                        exp_q.push_back(16'(acc >>> 2));
                        acc = 0;
                        cnt = 0;
                    end
                    pending = 0;
                    sent++;
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check("rand_unexpected", 32'(m_axis_tdata), 32'hFFFF_FFFF);
                    end else begin
                        check("rand_data", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
                    end
                    rcvd++;
                end
            end
            check("rand_outputs", 32'(rcvd), 32'd250);
            check("rand_leftover", 32'(exp_q.size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
